ro_puf_controller: RTL
======================

# ro_puf_controller

Sequences one challenge/response evaluation of the 16-oscillator ring-oscillator PUF. Each evaluation:
- accepts a challenge naming two oscillators;
- resets and enables only that pair, then waits for them to settle;
- counts rising edges of each over a fixed window;
- returns one response bit from the comparison.

It sits between the challenge source (host/UART logic) and the `Ring_Oscillator` array. It drives their `enable`/`rst` inputs and samples their `out` lines.

## Interface
- `NUM_RO`, 16: number of oscillators; index width is clog2(NUM_RO).
- `CNT_W`, 16: edge-counter width; counters saturate at 2^CNT_W-1.
- `SETTLE`, 16: settle cycles after oscillator reset release; must be ≥1.
- `WINDOW`, 1024: counting window in clk cycles; must be ≥1.
- `MARGIN`, 4: minimum |cnt_a-cnt_b| for a trusted bit (used only with the macro).

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `chal_valid` in 1: challenge offered.
- `chal_ready` out 1: controller can accept a challenge.
- `chal_a` in clog2(NUM_RO): first oscillator index.
- `chal_b` in clog2(NUM_RO): second oscillator index.
- `ro_en` out NUM_RO: per-oscillator enable.
- `ro_rst` out 1: active-high reset to the oscillator array.
- `ro_out` in NUM_RO: raw oscillator outputs; asynchronous.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer takes the response.
- `resp_bit` out 1: 1 when cnt_a > cnt_b.
- `resp_err` out 1: response is untrusted.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ORST, SETTLE, COUNT, CMP, RESP.
- **IDLE**
  - chal_ready=1.
  - On chal_valid&chal_ready: register chal_a/chal_b and go to ORST.
  - If chal_a==chal_b: skip to RESP with resp_bit=0, resp_err=1.
- **ORST**
  - 2 cycles; ro_rst=1.
  - ro_en has only bits a and b set.
  - Edge counters clear.
- **SETTLE**
  - SETTLE cycles; ro_rst=0 and ro_en held.
  - Edges are ignored.
- **COUNT**
  - WINDOW cycles; ro_en held.
  - Each selected output passes through a mux, a 2-flop synchronizer and an edge detector (0→1 of the synchronized value).
  - Each detected edge increments its saturating counter.
- **CMP**
  - 1 cycle; ro_en=0.
  - resp_bit = (cnt_a > cnt_b); a tie gives resp_bit=0 and resp_err=1.
- **RESP**
  - resp_valid=1; resp_bit and resp_err held stable.
  - On resp_ready: go to IDLE.
- Either counter saturated → resp_err=1.
- Outside ORST/SETTLE/COUNT: ro_en=0, ro_rst=0.
- Challenges presented while busy are not accepted: chal_ready=0 and no queuing.

## Timing
- Reset values:
  - state=IDLE, chal_ready=1.
  - ro_en=0, ro_rst=0.
  - resp_valid=0, resp_bit=0, resp_err=0, busy=0.
  - Counters 0.
- Latency from the accept edge to resp_valid high: 2+SETTLE+WINDOW+1 cycles. For a==b it is 1 cycle.
- resp_valid stays high until the cycle resp_ready is sampled high; the next challenge can be accepted the cycle after.
- resp_ready low in RESP stalls indefinitely; outputs do not change.
- An edge that occurs during SETTLE but is detected in COUNT's first 2 cycles (synchronizer delay) is counted. This is accepted by design.
- rst_n asserted mid-evaluation:
  - Immediately forces ro_en=0 and returns to IDLE.
  - Any pending response is dropped.
- Arithmetic:
  - Counters are unsigned CNT_W bits and saturating.
  - The difference is computed in CNT_W+1 bits, then its absolute value is taken.

## Configuration
- `RO_PUF_MARGIN_EN` defined:
  - CMP also sets resp_err=1 when |cnt_a-cnt_b| < MARGIN.
  - An extra output `resp_margin` [CNT_W-1:0] carries |cnt_a-cnt_b|; its reset value is 0 and it is held in RESP.
- Undefined: resp_err only flags a==b, ties and saturation. `resp_margin` is absent.

## Structure
- Package `ro_puf_pkg`:
  - state enum (IDLE, ORST, SETTLE, COUNT, CMP, RESP);
  - ORST_CYCLES=2;
  - index-width helper.
- Sub-module `ro_edge_counter` (2-flop synchronizer, edge detector, saturating counter, clear/enable inputs), instantiated twice (A and B).
- The top holds the FSM, cycle timer, challenge registers, mux and compare.

## Test plan
All scenarios use WINDOW=240 and SETTLE=16 unless stated.
- **Basic comparison:** chal_a=3 (model period 6 clk), chal_b=9 (period 8 clk) → counts 40/30; resp_bit=1, resp_err=0; resp_valid 259 cycles after accept; ro_en=16'h0208 during ORST/COUNT.
- **Swapped challenge:** chal_a=9, chal_b=3 → resp_bit=0, resp_err=0.
- **Same index and tie:** chal_a=chal_b=5 → resp_valid after 1 cycle, resp_bit=0, resp_err=1. Equal periods (8/8) → resp_err=1.
- **Back-pressure:** resp_ready held low 50 cycles → resp_valid and resp_bit stable. chal_valid pulsed during busy → not accepted (chal_ready=0).
- **Mid-window reset:** rst_n low at cycle 100 of COUNT → ro_en=0 and chal_ready=1 asynchronously. A fresh challenge after reset gives the correct result.
- **Margin and saturation:**
  - With RO_PUF_MARGIN_EN and periods 8/9 (30/26, margin 4 vs MARGIN=5) → resp_err=1, resp_margin=4.
  - CNT_W=4 → counters saturate at 15 and resp_err=1.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF controller.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ORST   = 3'd1,
    S_SETTLE = 3'd2,
    S_COUNT  = 3'd3,
    S_CMP    = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  localparam int ORST_CYCLES = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_puf_controller_if.sv
// Challenge/response handshake bundle; resp_margin exists only with RO_PUF_MARGIN_EN.
interface ro_puf_controller_if #(
  parameter int NUM_RO = 16,
  parameter int CNT_W  = 16
);
  import ro_puf_pkg::*;

  localparam int IDX_W = idx_w(NUM_RO);

  logic             chal_valid;
  logic             chal_ready;
  logic [IDX_W-1:0] chal_a;
  logic [IDX_W-1:0] chal_b;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_bit;
  logic             resp_err;
`ifdef RO_PUF_MARGIN_EN
  logic [CNT_W-1:0] resp_margin;
`endif

  modport master (
    output chal_valid, chal_a, chal_b, resp_ready,
`ifdef RO_PUF_MARGIN_EN
    input  resp_margin,
`endif
    input  chal_ready, resp_valid, resp_bit, resp_err
  );

  modport slave (
    input  chal_valid, chal_a, chal_b, resp_ready,
`ifdef RO_PUF_MARGIN_EN
    output resp_margin,
`endif
    output chal_ready, resp_valid, resp_bit, resp_err
  );

endinterface

// File: rtl/ro_edge_counter.sv
// Synchronizes one raw oscillator line, detects its rising edges and counts them (saturating).
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_din,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_sat;

  assign w_rise = r_s2 & ~r_s3;
  assign w_sat  = &r_cnt;
  assign o_cnt  = r_cnt;
  assign o_sat  = w_sat;

  // two-flop synchronizer plus previous-value flop for the edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // saturating edge counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && w_rise && !w_sat) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ro_puf_controller.sv
// Sequences one RO-PUF challenge/response evaluation over a selected oscillator pair.
// Optional feature macro: RO_PUF_MARGIN_EN (margin check and resp_margin output).
module ro_puf_controller
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO = 16,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 16,
  parameter int WINDOW = 1024,
  parameter int MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ro_puf_controller_if.slave bus,
  output logic [NUM_RO-1:0] ro_en,
  output logic              ro_rst,
  input  logic [NUM_RO-1:0] ro_out,
  output logic              busy
);

  localparam int IDX_W = idx_w(NUM_RO);
  localparam int TMR_W = $clog2(WINDOW + SETTLE + ORST_CYCLES + 1);
  localparam logic [TMR_W-1:0]  ORST_LD   = TMR_W'(ORST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0]  WINDOW_LD = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  MARGIN_V  = CNT_W'(MARGIN);
  localparam logic [NUM_RO-1:0] ONE_HOT0  = NUM_RO'(1);
`ifdef RO_PUF_MARGIN_EN
  localparam logic MARGIN_ON = 1'b1;
`else
  localparam logic MARGIN_ON = 1'b0;
`endif

  state_e            r_state;
  state_e            w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [IDX_W-1:0]  r_chal_a;
  logic [IDX_W-1:0]  r_chal_b;
  logic              r_same;
  logic [NUM_RO-1:0] r_ro_en;
  logic              r_ro_rst;
  logic              r_chal_ready;
  logic              r_busy;
  logic              r_resp_valid;
  logic              r_resp_bit;
  logic              r_resp_err;
  logic              w_accept;
  logic              w_timer_done;
  logic [IDX_W-1:0]  w_sel_a;
  logic [IDX_W-1:0]  w_sel_b;
  logic [NUM_RO-1:0] w_mask;
  logic [CNT_W-1:0]  w_cnt_a;
  logic [CNT_W-1:0]  w_cnt_b;
  logic              w_sat_a;
  logic              w_sat_b;
  logic [CNT_W:0]    w_diff;
  logic [CNT_W-1:0]  w_abs;
  logic              w_a_gt_b;
  logic              w_tie;
  logic              w_err;

  assign w_accept     = bus.chal_valid & r_chal_ready;
  assign w_timer_done = (r_timer == '0);
  assign w_sel_a      = w_accept ? bus.chal_a : r_chal_a;
  assign w_sel_b      = w_accept ? bus.chal_b : r_chal_b;
  assign w_mask       = (ONE_HOT0 << w_sel_a) | (ONE_HOT0 << w_sel_b);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .i_din (ro_out[r_chal_a]),
    .i_clr (r_state == S_ORST),
    .i_en  (r_state == S_COUNT),
    .o_cnt (w_cnt_a),
    .o_sat (w_sat_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .i_din (ro_out[r_chal_b]),
    .i_clr (r_state == S_ORST),
    .i_en  (r_state == S_COUNT),
    .o_cnt (w_cnt_b),
    .o_sat (w_sat_b)
  );

  // sign of the widened difference decides order; magnitude avoids a wide negate
  assign w_diff   = {1'b0, w_cnt_a} - {1'b0, w_cnt_b};
  assign w_tie    = (w_diff == '0);
  assign w_a_gt_b = ~w_diff[CNT_W] & ~w_tie;
  assign w_abs    = w_diff[CNT_W] ? (w_cnt_b - w_cnt_a) : w_diff[CNT_W-1:0];
  assign w_err    = w_tie | w_sat_a | w_sat_b | (MARGIN_ON & (w_abs < MARGIN_V));

  // next-state logic; a==b takes a single CMP cycle so its latency is one clock
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (bus.chal_a == bus.chal_b) ? S_CMP : S_ORST;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ORST:   w_state_nxt = w_timer_done ? S_SETTLE : S_ORST;
      S_SETTLE: w_state_nxt = w_timer_done ? S_COUNT : S_SETTLE;
      S_COUNT:  w_state_nxt = w_timer_done ? S_CMP : S_COUNT;
      S_CMP:    w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = bus.resp_ready ? S_IDLE : S_RESP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // state register and per-state cycle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          S_ORST:   r_timer <= ORST_LD;
          S_SETTLE: r_timer <= SETTLE_LD;
          S_COUNT:  r_timer <= WINDOW_LD;
          default:  r_timer <= '0;
        endcase
      end else if (!w_timer_done) begin
        r_timer <= r_timer - {{(TMR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // challenge capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chal_a <= '0;
      r_chal_b <= '0;
      r_same   <= 1'b0;
    end else if (w_accept) begin
      r_chal_a <= bus.chal_a;
      r_chal_b <= bus.chal_b;
      r_same   <= (bus.chal_a == bus.chal_b);
    end
  end

  // registered control outputs, decoded from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ro_en      <= '0;
      r_ro_rst     <= 1'b0;
      r_chal_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_ro_en      <= (w_state_nxt == S_ORST || w_state_nxt == S_SETTLE ||
                       w_state_nxt == S_COUNT) ? w_mask : '0;
      r_ro_rst     <= (w_state_nxt == S_ORST);
      r_chal_ready <= (w_state_nxt == S_IDLE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
    end
  end

  // response latched in CMP and held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_bit <= 1'b0;
      r_resp_err <= 1'b0;
    end else if (r_state == S_CMP) begin
      r_resp_bit <= r_same ? 1'b0 : w_a_gt_b;
      r_resp_err <= r_same | w_err;
    end else if (w_accept) begin
      r_resp_bit <= 1'b0;
      r_resp_err <= 1'b0;
    end
  end

`ifdef RO_PUF_MARGIN_EN
  logic [CNT_W-1:0] r_resp_margin;

  // margin latched alongside the response bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_margin <= '0;
    end else if (r_state == S_CMP) begin
      r_resp_margin <= r_same ? '0 : w_abs;
    end else if (w_accept) begin
      r_resp_margin <= '0;
    end
  end

  assign bus.resp_margin = r_resp_margin;
`endif

  assign ro_en          = r_ro_en;
  assign ro_rst         = r_ro_rst;
  assign busy           = r_busy;
  assign bus.chal_ready = r_chal_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_bit   = r_resp_bit;
  assign bus.resp_err   = r_resp_err;

endmodule
